// File: rtl/arbiter_wbuf.sv
// Arbitrates i-cache and d-cache line requests onto one memory port. A one-entry
// posted write buffer absorbs d-cache write-backs, coalesces same-line writes and
// forwards buffered data to matching d-cache reads. The buffer drains when idle.
module arbiter_wbuf #(
    parameter int unsigned s_offset = 5,
    parameter int unsigned s_line   = 8 * 2**s_offset
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cache_read,
    input  logic [31:0]       i_cache_addr,
    output logic [s_line-1:0] i_cache_rdata,
    output logic              i_cache_resp,
    input  logic              d_cache_read,
    input  logic              d_cache_write,
    input  logic [31:0]       d_cache_addr,
    input  logic [s_line-1:0] d_cache_wdata,
    output logic [s_line-1:0] d_cache_rdata,
    output logic              d_cache_resp,
    output logic              ca_read,
    output logic              ca_write,
    output logic [31:0]       ca_addr,
    output logic [s_line-1:0] ca_wdata,
    input  logic [s_line-1:0] ca_rdata,
    input  logic              ca_resp
);

    typedef enum logic [2:0] {StIdle, StIRd, StDRd, StDrain, StDAck} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic              r_wb_valid;
    logic [31:0]       r_wb_addr;
    logic [s_line-1:0] r_wb_data;
    // 1 when the most recent read grant went to the d-cache
    logic              r_last_d;

    logic w_match;
    logic w_d_hit;
    logic w_d_miss;
    logic w_wb_load;
    logic w_wb_clear;
    logic w_grant_d;
    logic w_grant_i;

    // Line match ignores the byte offset within the line
    assign w_match  = (d_cache_addr[31:s_offset] == r_wb_addr[31:s_offset]);
    assign w_d_hit  = r_wb_valid && w_match;
    assign w_d_miss = d_cache_read && !w_d_hit;

    // State, write buffer and fairness bit registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_last_d   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_wb_load) begin
                r_wb_valid <= 1'b1;
                r_wb_addr  <= d_cache_addr;
                r_wb_data  <= d_cache_wdata;
            end else if (w_wb_clear) begin
                r_wb_valid <= 1'b0;
            end
            if (w_grant_d) begin
                r_last_d <= 1'b1;
            end else if (w_grant_i) begin
                r_last_d <= 1'b0;
            end
        end
    end

    // Next-state decode with request priority evaluated only in idle
    always_comb begin
        w_state_next = r_state;
        w_wb_load    = 1'b0;
        w_wb_clear   = 1'b0;
        w_grant_d    = 1'b0;
        w_grant_i    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (d_cache_write && (!r_wb_valid || w_match)) begin
                    // Empty buffer or same line: absorb (overwrite) without memory traffic
                    w_wb_load    = 1'b1;
                    w_state_next = StDAck;
                end else if (d_cache_write) begin
                    // Different line already buffered: flush it first, write retried after
                    w_state_next = StDrain;
                end else if (d_cache_read && w_d_hit) begin
                    w_state_next = StDAck;
                end else if (w_d_miss && i_cache_read) begin
                    w_grant_d    = !r_last_d;
                    w_grant_i    = r_last_d;
                    w_state_next = r_last_d ? StIRd : StDRd;
                end else if (w_d_miss) begin
                    w_grant_d    = 1'b1;
                    w_state_next = StDRd;
                end else if (i_cache_read) begin
                    w_grant_i    = 1'b1;
                    w_state_next = StIRd;
                end else if (r_wb_valid) begin
                    w_state_next = StDrain;
                end
            end
            StIRd, StDRd: begin
                if (ca_resp) begin
                    w_state_next = StIdle;
                end
            end
            StDrain: begin
                if (ca_resp) begin
                    w_wb_clear   = 1'b1;
                    w_state_next = StIdle;
                end
            end
            StDAck: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Outputs decoded from state; memory-side signals held for the whole op
    always_comb begin
        i_cache_rdata = '0;
        i_cache_resp  = 1'b0;
        d_cache_rdata = '0;
        d_cache_resp  = 1'b0;
        ca_read       = 1'b0;
        ca_write      = 1'b0;
        ca_addr       = '0;
        ca_wdata      = '0;
        unique case (r_state)
            StIdle: begin
            end
            StIRd: begin
                ca_read       = 1'b1;
                ca_addr       = i_cache_addr;
                i_cache_rdata = ca_rdata;
                i_cache_resp  = ca_resp;
            end
            StDRd: begin
                ca_read       = 1'b1;
                ca_addr       = d_cache_addr;
                d_cache_rdata = ca_rdata;
                d_cache_resp  = ca_resp;
            end
            StDrain: begin
                ca_write = 1'b1;
                ca_addr  = r_wb_addr;
                ca_wdata = r_wb_data;
            end
            StDAck: begin
                d_cache_resp  = 1'b1;
                d_cache_rdata = r_wb_data;
            end
            default: begin
            end
        endcase
    end

endmodule
